// File: rtl/nibble_serializer_pkg.sv
// Shared types and helpers for the 4-bit UART-style serializer.
package nibble_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DATA_BITS = 4;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Parallel-in handshake plus serial-out status bundle of the serializer.
interface nibble_serializer_if;
    import nibble_serializer_pkg::*;

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 serial_out;
    logic                 busy;
    logic                 done;

    modport slave (
        input  in_data, in_valid,
        output in_ready, serial_out, busy, done
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, serial_out, busy, done
    );

endinterface

// File: rtl/nibble_serializer_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and
// second-to-last cycle of each bit period.
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);
    // With one clock per bit there is no second-to-last cycle.
    assign pre_tick = (CLKS_PER_BIT > 1) && (cnt_q == PRE);

endmodule

// File: rtl/nibble_serializer.sv
// Accepts a 4-bit word on a valid/ready handshake and sends it as
// start / 4 data / optional even parity / stop, each bit CLKS_PER_BIT cycles.
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    nibble_serializer_if.slave bus
);
    state_t               state_q, state_d;
    logic [1:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick, pre_tick;
    logic                 head;
    logic [DATA_BITS-1:0] shifted;

    baud_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q == IDLE),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // The next data bit is always at the outgoing end of the shift register.
    assign head    = MSB_FIRST ? shreg_q[DATA_BITS-1] : shreg_q[0];
    assign shifted = MSB_FIRST ? {shreg_q[DATA_BITS-2:0], 1'b0}
                               : {1'b0, shreg_q[DATA_BITS-1:1]};

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        serial_d = serial_q;
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                if (bus.in_valid) begin
                    state_d  = START;
                    shreg_d  = bus.in_data;
                    parity_d = even_parity(bus.in_data);
                    serial_d = 1'b0;
                end
            end
            START: if (tick) begin
                state_d  = DATA;
                bit_d    = 2'd0;
                serial_d = head;
                shreg_d  = shifted;
            end
            DATA: if (tick) begin
                if (bit_q == 2'd3) begin
                    bit_d = 2'd0;
                    if (PARITY_EN) begin
                        state_d  = PARITY;
                        serial_d = parity_q;
                    end else begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end
                end else begin
                    bit_d    = bit_q + 2'd1;
                    serial_d = head;
                    shreg_d  = shifted;
                end
            end
            PARITY: if (tick) begin
                state_d  = STOP;
                serial_d = 1'b1;
            end
            STOP: if (tick) begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
        // done is registered, so it is raised on the edge into STOP's last cycle.
        done_d = (state_d == STOP) &&
                 ((CLKS_PER_BIT == 1) || (state_q == STOP && pre_tick));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bit_q    <= 2'd0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.serial_out = serial_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Scenario bench for nibble_serializer: a default instance and a
// CLKS_PER_BIT=1 / no-parity / MSB-first instance checked against a frame model.
module tb_nibble_serializer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nibble_serializer_if bus_a ();
    nibble_serializer_if bus_b ();

    nibble_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    nibble_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    int n_cmp = 0;
    int n_bad = 0;

    localparam int LA = 28;   // 4 * (6+1)
    localparam int LB = 6;    // 1 * (6+0)

    // Line level in cycle k (1-based) of a frame: slot 0 start, 1..4 data,
    // then parity if enabled, then stop.
    function automatic logic model_level(input logic [3:0] d, input int c,
                                         input bit par, input bit msb, input int k);
        int slot;
        slot = (k - 1) / c;
        if (slot == 0) return 1'b0;
        if (slot <= 4) return msb ? d[4 - slot] : d[slot - 1];
        if (par && slot == 5) return ^d;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        bus_a.in_valid = 1'b0; bus_a.in_data = 4'h0;
        bus_b.in_valid = 1'b0; bus_b.in_data = 4'h0;
        #2 reset = 1'b0;
        #2;
        obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL reset_hold: {ser,busy,done,rdy}=%b want 1001", obs);
        end
        step(); step();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== 4'b1001) begin
                n_bad++;
                $display("FAIL reset_idle_a cycle %0d: {ser,busy,done,rdy}=%b want 1001", k, obs);
            end
            obs = {bus_b.serial_out, bus_b.busy, bus_b.done, bus_b.in_ready};
            n_cmp++;
            if (obs !== 4'b1001) begin
                n_bad++;
                $display("FAIL reset_idle_b cycle %0d: {ser,busy,done,rdy}=%b want 1001", k, obs);
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [3:0] obs, exp;
        logic [3:0] d;
        d = 4'b1010;
        bus_a.in_data = d; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0;
        for (int k = 1; k <= LA; k++) begin
            exp = {model_level(d, 4, 1'b1, 1'b0, k), 1'b1, (k == LA), 1'b0};
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL basic_frame cycle %0d: {ser,busy,done,rdy}=%b want %b", k, obs, exp);
            end
            bus_a.in_data = 4'($urandom);
            step();
        end
        obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL basic_frame_end: {ser,busy,done,rdy}=%b want 1001", obs);
        end
    endtask

    task automatic test_msb_fast();
        logic [3:0] obs, exp;
        logic [3:0] d;
        for (int f = 0; f < 6; f++) begin
            d = (f == 0) ? 4'b0111 : 4'($urandom);
            bus_b.in_data = d; bus_b.in_valid = 1'b1;
            step();
            bus_b.in_valid = 1'b0;
            for (int k = 1; k <= LB; k++) begin
                exp = {model_level(d, 1, 1'b0, 1'b1, k), 1'b1, (k == LB), 1'b0};
                obs = {bus_b.serial_out, bus_b.busy, bus_b.done, bus_b.in_ready};
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++;
                    $display("FAIL msb_fast d=%b cycle %0d: {ser,busy,done,rdy}=%b want %b", d, k, obs, exp);
                end
                bus_b.in_data = 4'($urandom);
                step();
            end
            obs = {bus_b.serial_out, bus_b.busy, bus_b.done, bus_b.in_ready};
            n_cmp++;
            if (obs !== 4'b1001) begin
                n_bad++;
                $display("FAIL msb_fast_end d=%b: {ser,busy,done,rdy}=%b want 1001", d, obs);
            end
        end
    endtask

    task automatic test_random_frames();
        logic [3:0] obs, exp;
        logic [3:0] d;
        int gap;
        for (int f = 0; f < 8; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bus_a.in_valid = 1'b0;
                step();
                obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
                n_cmp++;
                if (obs !== 4'b1001) begin
                    n_bad++;
                    $display("FAIL random_gap: {ser,busy,done,rdy}=%b want 1001", obs);
                end
            end
            d = 4'($urandom);
            bus_a.in_data = d; bus_a.in_valid = 1'b1;
            step();
            for (int k = 1; k <= LA; k++) begin
                exp = {model_level(d, 4, 1'b1, 1'b0, k), 1'b1, (k == LA), 1'b0};
                obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++;
                    $display("FAIL random_frame d=%b cycle %0d: {ser,busy,done,rdy}=%b want %b", d, k, obs, exp);
                end
                bus_a.in_valid = 1'($urandom);
                bus_a.in_data  = 4'($urandom);
                step();
            end
            bus_a.in_valid = 1'b0;
        end
    endtask

    task automatic test_ignore_busy();
        logic [3:0] obs, exp;
        bus_a.in_data = 4'b1010; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_data = 4'b0101;
        for (int k = 1; k <= LA; k++) begin
            exp = {model_level(4'b1010, 4, 1'b1, 1'b0, k), 1'b1, (k == LA), 1'b0};
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL ignore_busy_first cycle %0d: {ser,busy,done,rdy}=%b want %b", k, obs, exp);
            end
            step();
        end
        obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL ignore_busy_gap: {ser,busy,done,rdy}=%b want 1001", obs);
        end
        step();
        bus_a.in_valid = 1'b0;
        for (int k = 1; k <= LA; k++) begin
            exp = {model_level(4'b0101, 4, 1'b1, 1'b0, k), 1'b1, (k == LA), 1'b0};
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL ignore_busy_second cycle %0d: {ser,busy,done,rdy}=%b want %b", k, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] obs, exp;
        bus_a.in_data = 4'b1111; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0;
        // Cycles 9..12 carry the second data bit.
        for (int k = 1; k <= 10; k++) begin
            exp = {model_level(4'b1111, 4, 1'b1, 1'b0, k), 1'b1, 1'b0, 1'b0};
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL abort_pre cycle %0d: {ser,busy,done,rdy}=%b want %b", k, obs, exp);
            end
            if (k < 10) step();
        end
        #2 reset = 1'b0;
        #1;
        obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL abort_immediate: {ser,busy,done,rdy}=%b want 1001", obs);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== 4'b1001) begin
                n_bad++;
                $display("FAIL abort_hold cycle %0d: {ser,busy,done,rdy}=%b want 1001", k, obs);
            end
        end
        reset = 1'b1;
        step();
        bus_a.in_data = 4'b0001; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0;
        for (int k = 1; k <= LA + 1; k++) begin
            if (k <= LA) exp = {model_level(4'b0001, 4, 1'b1, 1'b0, k), 1'b1, (k == LA), 1'b0};
            else         exp = 4'b1001;
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL abort_restart cycle %0d: {ser,busy,done,rdy}=%b want %b", k, obs, exp);
            end
            if (k <= LA) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, exp;
        bus_a.in_data = 4'b0011; bus_a.in_valid = 1'b1;
        step();
        for (int f = 0; f < 3; f++) begin
            for (int k = 1; k <= LA; k++) begin
                exp = {model_level(4'b0011, 4, 1'b1, 1'b0, k), 1'b1, (k == LA), 1'b0};
                obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++;
                    $display("FAIL back_to_back f=%0d cycle %0d: {ser,busy,done,rdy}=%b want %b", f, k, obs, exp);
                end
                step();
            end
            obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
            n_cmp++;
            if (obs !== 4'b1001) begin
                n_bad++;
                $display("FAIL back_to_back_gap f=%0d: {ser,busy,done,rdy}=%b want 1001", f, obs);
            end
            if (f == 2) bus_a.in_valid = 1'b0;
            step();
        end
        obs = {bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.in_ready};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL back_to_back_end: {ser,busy,done,rdy}=%b want 1001", obs);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_msb_fast();
        test_random_frames();
        step();
        test_ignore_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
